// File: rtl/isqrt_arb_pkg.sv
// Shared definitions for the isqrt round-robin arbiter slice.
package isqrt_arb_pkg;

    localparam int unsigned ISQRT_X_W = 32;
    localparam int unsigned ISQRT_Y_W = 16;

    // Upper bound on requesters handled by rr_pick; callers zero-extend.
    localparam int unsigned RR_MAX = 16;
    localparam int unsigned RR_IW  = 4;

    typedef enum logic [1:0] {
        st_idle = 2'd0,
        st_busy = 2'd1,
        st_full = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic              found;
        logic [RR_IW-1:0]  idx;
    } rr_pick_t;

    // Round-robin search: first asserted vld bit at or after ptr, wrapping
    // modulo n (n <= RR_MAX, ptr < n).
    function automatic rr_pick_t rr_pick(
        input logic [RR_MAX-1:0] vld,
        input logic [RR_IW-1:0]  ptr,
        input int unsigned       n
    );
        rr_pick_t    r;
        int unsigned j;
        r = '0;
        for (int unsigned k = 0; k < RR_MAX; k++) begin
            j = 32'(ptr) + k;
            if (j >= n) begin
                j = j - n;
            end
            if ((k < n) && !r.found && vld[j[RR_IW-1:0]]) begin
                r.found = 1'b1;
                r.idx   = j[RR_IW-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/isqrt_tag_fifo.sv
// In-order tag FIFO: remembers which requester issued each outstanding
// isqrt operand so results can be routed back in issue order.
module isqrt_tag_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [W-1:0]               head,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Guard the pointers against overflow/underflow.
    always_comb begin
        empty   = (count == '0);
        full    = (count == (AW+1)'(DEPTH));
        do_push = push && !full;
        do_pop  = pop && !empty;
        head    = mem[rd_ptr];
    end

    // Tag storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/isqrt_rr_arbiter.sv
// Round-robin sharing of one in-order isqrt unit between N_REQ requesters.
// Grants are combinational; results are routed back via an in-order tag FIFO
// and presented one cycle after the unit returns them.
module isqrt_rr_arbiter
    import isqrt_arb_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned MAX_OUT = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [N_REQ-1:0]                  req_vld,
    input  logic [N_REQ-1:0][ISQRT_X_W-1:0]   req_x,
    output logic [N_REQ-1:0]                  req_rdy,
    output logic [N_REQ-1:0]                  rsp_vld,
    output logic [ISQRT_Y_W-1:0]              rsp_y,
    output logic                              isqrt_x_vld,
    output logic [ISQRT_X_W-1:0]              isqrt_x,
    input  logic                              isqrt_y_vld,
    input  logic [ISQRT_Y_W-1:0]              isqrt_y,
    output logic                              busy,
    output logic                              err
);

    localparam int unsigned PW = $clog2(N_REQ);
    localparam int unsigned CW = $clog2(MAX_OUT) + 1;

    logic [PW-1:0]     ptr;
    arb_state_t        state;
    arb_state_t        state_nxt;
    logic [CW-1:0]     count;
    logic [CW-1:0]     next_count;
    logic              fifo_empty;
    logic              fifo_full;
    logic [PW-1:0]     head;
    logic [RR_MAX-1:0] vld_ext;
    rr_pick_t          pick;
    logic              grant;
    logic [PW-1:0]     gnt_idx;
    logic              pop;

    // Round-robin pick among valid requesters; eligibility uses the
    // registered count only, so a same-cycle pop never frees a slot.
    always_comb begin
        vld_ext              = '0;
        vld_ext[N_REQ-1:0]   = req_vld;
        pick                 = rr_pick(vld_ext, RR_IW'(ptr), N_REQ);
        gnt_idx              = pick.idx[PW-1:0];
        grant                = pick.found && (count < CW'(MAX_OUT)) && (state != st_full);
        req_rdy              = grant ? (N_REQ'(1) << gnt_idx) : '0;
        isqrt_x_vld          = grant;
        isqrt_x              = grant ? req_x[gnt_idx] : '0;
        pop                  = isqrt_y_vld && !fifo_empty;
    end

    // Occupancy after this cycle's push/pop, used to derive the next state.
    always_comb begin
        next_count = count;
        case ({grant, pop})
            2'b10:   next_count = count + 1'b1;
            2'b01:   next_count = count - 1'b1;
            default: next_count = count;
        endcase
        if (next_count == '0) begin
            state_nxt = st_idle;
        end else if (next_count == CW'(MAX_OUT)) begin
            state_nxt = st_full;
        end else begin
            state_nxt = st_busy;
        end
        busy = (state != st_idle);
    end

    isqrt_tag_fifo #(
        .DEPTH (MAX_OUT),
        .W     (PW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (grant),
        .push_data (gnt_idx),
        .pop       (pop),
        .head      (head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (count)
    );

    // Advance the round-robin pointer past the last granted requester.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (grant) begin
            ptr <= (gnt_idx == PW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Occupancy state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= st_idle;
        end else begin
            state <= state_nxt;
        end
    end

    // Response register: one-cycle pulse to the head tag, data held otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_vld <= '0;
            rsp_y   <= '0;
        end else begin
            rsp_vld <= pop ? (N_REQ'(1) << head) : '0;
            if (pop) begin
                rsp_y <= isqrt_y;
            end
        end
    end

    // Sticky error on a result with nothing outstanding.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (isqrt_y_vld && fifo_empty) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_isqrt_rr_arbiter.sv
// Self-checking bench for isqrt_rr_arbiter: queue-based reference model with a
// per-cycle compare process, plus directed scenarios with literal expectations.
module tb_isqrt_rr_arbiter;
    import isqrt_arb_pkg::*;

    localparam int N       = 4;
    localparam int MAX_OUT = 8;
    localparam int LAT     = 3;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [N-1:0]        req_vld = '0;
    logic [N-1:0][31:0]  req_x   = '0;
    logic [N-1:0]        req_rdy;
    logic [N-1:0]        rsp_vld;
    logic [15:0]         rsp_y;
    logic                isqrt_x_vld;
    logic [31:0]         isqrt_x;
    logic                isqrt_y_vld = 1'b0;
    logic [15:0]         isqrt_y     = '0;
    logic                busy;
    logic                err;

    isqrt_rr_arbiter #(.N_REQ(N), .MAX_OUT(MAX_OUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_vld     (req_vld),
        .req_x       (req_x),
        .req_rdy     (req_rdy),
        .rsp_vld     (rsp_vld),
        .rsp_y       (rsp_y),
        .isqrt_x_vld (isqrt_x_vld),
        .isqrt_x     (isqrt_x),
        .isqrt_y_vld (isqrt_y_vld),
        .isqrt_y     (isqrt_y),
        .busy        (busy),
        .err         (err)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned isq(input int unsigned x);
        int unsigned r = 0;
        while ((r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    // Requester operand queues and isqrt-unit behaviour
    typedef struct { int unsigned y; int unsigned rdy; } iq_t;
    int unsigned rq [N][$];
    iq_t         iq [$];
    int unsigned cyc = 0;
    bit          stall = 0;
    int          rel = 0;
    bit          auto_y = 1;
    bit          man_vld = 0;
    logic [15:0] man_y = '0;

    // Logs of what the DUT actually did
    int          grant_log [$];
    int          rsp_log   [$];
    int unsigned dut_got   [N][$];

    // Reference model state
    bit          model_on = 0;
    int          mq [$];
    int          mptr = 0;
    bit          m_err = 0;
    logic [N-1:0] m_rsp_vld = '0;
    logic [15:0]  m_rsp_y = '0;

    // Requesters present the head of their queue until granted.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < N; i++) begin
            if (rq[i].size() > 0) begin
                req_vld[i] = 1'b1;
                req_x[i]   = rq[i][0];
            end else begin
                req_vld[i] = 1'b0;
                req_x[i]   = '0;
            end
        end
    end

    // In-order isqrt unit with fixed latency, optional stall and release tokens.
    always @(posedge clk) begin
        #2;
        if (!auto_y) begin
            isqrt_y_vld = man_vld;
            isqrt_y     = man_y;
        end else if (iq.size() > 0 && iq[0].rdy <= cyc && (!stall || rel > 0)) begin
            isqrt_y_vld = 1'b1;
            isqrt_y     = 16'(iq[0].y);
            void'(iq.pop_front());
            if (stall) rel--;
        end else begin
            isqrt_y_vld = 1'b0;
        end
    end

    // Compare DUT against the model, then advance the model over the coming edge.
    always @(negedge clk) begin
        int g;
        int t;
        logic [N-1:0]  exp_rdy;
        logic [31:0]   exp_x;
        g = -1;
        if (model_on) begin
            if (mq.size() < MAX_OUT) begin
                for (int k = 0; k < N; k++) begin
                    if (g < 0 && req_vld[(mptr + k) % N]) g = (mptr + k) % N;
                end
            end
            exp_rdy = (g >= 0) ? N'(1 << g) : '0;
            exp_x   = (g >= 0) ? req_x[g] : '0;
            chk("req_rdy", 64'(req_rdy), 64'(exp_rdy));
            chk("isqrt_x_vld", 64'(isqrt_x_vld), 64'(g >= 0));
            chk("isqrt_x", 64'(isqrt_x), 64'(exp_x));
            chk("rsp_vld", 64'(rsp_vld), 64'(m_rsp_vld));
            chk("rsp_y", 64'(rsp_y), 64'(m_rsp_y));
            chk("busy", 64'(busy), 64'(mq.size() != 0));
            chk("err", 64'(err), 64'(m_err));
        end
        for (int i = 0; i < N; i++) begin
            if (req_rdy[i]) grant_log.push_back(i);
            if (rsp_vld[i]) begin
                rsp_log.push_back(i);
                dut_got[i].push_back(32'(rsp_y));
            end
        end
        if (rst) begin
            mq.delete();
            iq.delete();
            for (int i = 0; i < N; i++) rq[i].delete();
            mptr      = 0;
            m_err     = 0;
            m_rsp_vld = '0;
            m_rsp_y   = '0;
            model_on  = 1;
        end else if (model_on) begin
            m_rsp_vld = '0;
            if (isqrt_y_vld) begin
                if (mq.size() > 0) begin
                    t = mq.pop_front();
                    m_rsp_vld = N'(1 << t);
                    m_rsp_y   = isqrt_y;
                end else begin
                    m_err = 1;
                end
            end
            if (g >= 0) begin
                mq.push_back(g);
                mptr = (g + 1) % N;
                iq.push_back('{y: isq(req_x[g]), rdy: cyc + LAT});
                void'(rq[g].pop_front());
            end
        end
        cyc++;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic clear_logs();
        grant_log.delete();
        rsp_log.delete();
        for (int i = 0; i < N; i++) dut_got[i].delete();
    endtask

    int unsigned xs [N] = '{1, 4, 9, 25};
    int unsigned ys [N] = '{1, 2, 3, 5};
    bit ok;

    initial begin
        // Reset values
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        step();
        chk("rst_req_rdy", 64'(req_rdy), 64'(0));
        chk("rst_rsp_vld", 64'(rsp_vld), 64'(0));
        chk("rst_rsp_y", 64'(rsp_y), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_ptr", 64'(dut.ptr), 64'(0));

        // Single requester: 16 -> 4
        clear_logs();
        rq[0].push_back(16);
        step();
        chk("single_rdy", 64'(req_rdy), 64'(4'b0001));
        chk("single_x", 64'(isqrt_x), 64'(16));
        ok = 0;
        for (int k = 0; k < 20 && !ok; k++) begin
            step();
            ok = (dut_got[0].size() > 0);
        end
        chk("single_timeout", 64'(ok), 64'(1));
        chk("single_y", 64'(dut_got[0].size() > 0 ? dut_got[0][0] : 0), 64'(4));
        step();
        chk("single_busy_end", 64'(busy), 64'(0));

        // Round-robin fairness
        do_reset();
        clear_logs();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++) rq[i].push_back(xs[i]);
        ok = 0;
        for (int k = 0; k < 60 && !ok; k++) begin
            step();
            ok = (rsp_log.size() >= 8);
        end
        chk("rr_timeout", 64'(ok), 64'(1));
        for (int k = 0; k < 8; k++) begin
            chk("rr_grant_order", 64'(k < grant_log.size() ? grant_log[k] : -1), 64'(k % N));
            chk("rr_rsp_order", 64'(k < rsp_log.size() ? rsp_log[k] : -1), 64'(k % N));
        end
        for (int i = 0; i < N; i++) begin
            chk("rr_rsp_y", 64'(dut_got[i].size() > 0 ? dut_got[i][0] : 0), 64'(ys[i]));
        end

        // Backpressure: exactly MAX_OUT grants while results stall
        do_reset();
        clear_logs();
        stall = 1;
        for (int k = 0; k < 5; k++) begin
            rq[0].push_back(100 + k);
            rq[3].push_back(200 + k);
        end
        repeat (14) step();
        chk("bp_grants", 64'(grant_log.size()), 64'(MAX_OUT));
        chk("bp_rdy_zero", 64'(req_rdy), 64'(0));
        chk("bp_state_full", 64'(dut.state), 64'(st_full));
        rel = 1;
        step();
        chk("bp_pop_cycle_rdy", 64'(req_rdy), 64'(0));
        step();
        chk("bp_regrant", 64'(req_rdy), 64'(4'b0001));
        step();
        chk("bp_full_again", 64'(req_rdy), 64'(0));
        stall = 0;
        ok = 0;
        for (int k = 0; k < 60 && !ok; k++) begin
            step();
            ok = (busy == 1'b0) && (rq[0].size() == 0) && (rq[3].size() == 0);
        end
        chk("bp_drain_timeout", 64'(ok), 64'(1));
        chk("bp_total_grants", 64'(grant_log.size()), 64'(10));

        // Simultaneous push and pop at count 3
        do_reset();
        clear_logs();
        stall = 1;
        rel = 0;
        rq[0].push_back(4);
        rq[0].push_back(9);
        rq[0].push_back(16);
        ok = 0;
        for (int k = 0; k < 10 && !ok; k++) begin
            step();
            ok = (grant_log.size() >= 3);
        end
        chk("pp_fill_timeout", 64'(ok), 64'(1));
        rq[2].push_back(49);
        rel = 1;
        step();
        chk("pp_grant2", 64'(req_rdy), 64'(4'b0100));
        chk("pp_ypop", 64'(isqrt_y_vld), 64'(1));
        chk("pp_count_before", 64'(dut.u_fifo.count), 64'(3));
        step();
        chk("pp_count_after", 64'(dut.u_fifo.count), 64'(3));
        chk("pp_rsp_vld", 64'(rsp_vld), 64'(4'b0001));
        chk("pp_rsp_y", 64'(rsp_y), 64'(2));
        stall = 0;
        ok = 0;
        for (int k = 0; k < 30 && !ok; k++) begin
            step();
            ok = (rsp_log.size() >= 4);
        end
        chk("pp_drain_timeout", 64'(ok), 64'(1));
        chk("pp_last_tag", 64'(rsp_log.size() >= 4 ? rsp_log[3] : -1), 64'(2));
        chk("pp_tag2_y", 64'(dut_got[2].size() > 0 ? dut_got[2][0] : 0), 64'(7));

        // Stray result
        do_reset();
        clear_logs();
        auto_y  = 0;
        man_y   = 16'd123;
        man_vld = 1;
        step();
        man_vld = 0;
        step();
        chk("stray_err", 64'(err), 64'(1));
        chk("stray_no_rsp", 64'(rsp_vld), 64'(0));
        repeat (3) step();
        chk("stray_sticky", 64'(err), 64'(1));
        chk("stray_no_rsp_log", 64'(rsp_log.size()), 64'(0));
        auto_y = 1;
        do_reset();
        step();
        chk("stray_cleared", 64'(err), 64'(0));

        // Reset with five operations outstanding
        clear_logs();
        stall = 1;
        rel = 0;
        for (int k = 0; k < 5; k++) rq[1].push_back(36 + k);
        ok = 0;
        for (int k = 0; k < 15 && !ok; k++) begin
            step();
            ok = (grant_log.size() >= 5);
        end
        chk("mid_fill_timeout", 64'(ok), 64'(1));
        do_reset();
        stall = 0;
        step();
        chk("mid_busy", 64'(busy), 64'(0));
        chk("mid_ptr", 64'(dut.ptr), 64'(0));
        chk("mid_rsp_vld", 64'(rsp_vld), 64'(0));
        chk("mid_rsp_y", 64'(rsp_y), 64'(0));
        chk("mid_err", 64'(err), 64'(0));
        clear_logs();
        rq[2].push_back(81);
        step();
        chk("mid_grant2", 64'(req_rdy), 64'(4'b0100));
        chk("mid_x", 64'(isqrt_x), 64'(81));
        ok = 0;
        for (int k = 0; k < 20 && !ok; k++) begin
            step();
            ok = (dut_got[2].size() > 0);
        end
        chk("mid_rsp_timeout", 64'(ok), 64'(1));
        chk("mid_rsp_y2", 64'(dut_got[2].size() > 0 ? dut_got[2][0] : 0), 64'(9));
        repeat (5) step();
        chk("mid_no_stale", 64'(rsp_log.size()), 64'(1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1);
    end

endmodule

// File: doc/isqrt_rr_arbiter.md
# isqrt_rr_arbiter

- Shares one isqrt unit between `N_REQ` independent requesters.
- Arbitration is round-robin. Each granted operand is issued to the unit, and the requester index is recorded in an in-order tag FIFO.
- Each result is routed back to the requester that issued the operand.
- Sits between formula FSMs (clients) and a single isqrt instance, which may be pipelined or multi-cycle but must return results in issue order.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters, 2..16.
- `MAX_OUT`, default 8: maximum outstanding isqrt operations; tag FIFO depth. Power of two, 2..64.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `req_vld`  in  `N_REQ`  requester i has an operand.
- `req_x`  in  `N_REQ`×32  operand per requester.
- `req_rdy`  out  `N_REQ`  one-hot grant; operand accepted this cycle.
- `rsp_vld`  out  `N_REQ`  one-hot; result for requester i.
- `rsp_y`  out  16  result, shared by all requesters.
- `isqrt_x_vld`  out  1  issue to isqrt.
- `isqrt_x`  out  32  operand to isqrt.
- `isqrt_y_vld`  in  1  isqrt result valid.
- `isqrt_y`  in  16  isqrt result.
- `busy`  out  1  outstanding count ≠ 0.
- `err`  out  1  sticky: `isqrt_y_vld` arrived with no tag outstanding.

## Operation
- **Grant eligibility:** a grant happens only when `count < MAX_OUT`. This uses the registered count; a same-cycle pop is not considered.
- **Grant selection:** search starts at `ptr` and wraps modulo `N_REQ`. The first i with `req_vld[i]` is granted.
- **Grant outputs (combinational, same cycle):**
  - `req_rdy[i]=1`, `isqrt_x_vld=1`, `isqrt_x=req_x[i]`.
  - When not granting: `isqrt_x_vld=0` and `isqrt_x=0`.
- **Pointer update:** on a grant to i, `ptr <= (i+1) mod N_REQ`. With no grant, `ptr` holds.
- **Tag push:** on a grant, index i is pushed into the tag FIFO.
- **Tag pop:** on `isqrt_y_vld` with the FIFO non-empty, the head tag t is popped. Next cycle: `rsp_vld[t]=1` and `rsp_y=isqrt_y`.
- **Count:**
  - +1 on push, −1 on pop.
  - Simultaneous push and pop leaves the count unchanged.
  - Pointers wrap modulo `MAX_OUT`.
- **Stray result:** `isqrt_y_vld` with the FIFO empty sets `err`. No pop and no `rsp_vld`. `err` clears only on reset.
- **Requester protocol:**
  - A requester holds `req_vld` and `req_x` until `req_rdy`.
  - It may drop `req_vld` before being granted; no state is affected.
- **FSM `st_idle` / `st_busy` / `st_full`:**
  - `st_idle` when count=0, `st_busy` when 0<count<`MAX_OUT`, `st_full` when count=`MAX_OUT`.
  - The state is derived from next_count and registered.
  - `busy = (state != st_idle)`.
  - No grants in `st_full`.

## Timing
- **Reset values:** `ptr=0`, `count=0`, state `st_idle`, `rsp_vld=0`, `rsp_y=0`, `err=0`, FIFO empty.
- **Combinational outputs after reset:** `req_rdy=0` and `isqrt_x_vld=0` until `req_vld` is sampled.
- **Issue latency:** 0 cycles from `req_vld` to grant when eligible.
- **Response latency:** `rsp_vld` is exactly 1 cycle after `isqrt_y_vld`.
- **Throughput:** one issue and one response per cycle, sustained.
- **Full boundary:** the cycle after count reaches `MAX_OUT`, no grant. The first grant comes the cycle after a pop lowers the count.
- **Reset mid-operation:**
  - Outstanding tags are discarded and no `rsp_vld` is produced for them.
  - The isqrt unit must be reset by the same `rst`.
- **Response pulse:** `rsp_vld` is a single-cycle pulse per result. `rsp_y` holds its last value when `rsp_vld=0`.

## Structure
- **Package `isqrt_arb_pkg`:**
  - `ISQRT_X_W=32`, `ISQRT_Y_W=16`.
  - State enum `arb_state_t`.
  - Function `rr_pick(vld, ptr)` returning the granted index plus a found flag.
- **Sub-module `isqrt_tag_fifo`:**
  - Parameters `DEPTH`, `W=$clog2(N_REQ)`.
  - Ports: push, push_data, pop, head, empty, full, count.
- **Top level:** contains the arbiter, the FSM and the response register.

## Test plan
- **Single requester:** `req_x[0]=16`, isqrt returns 4 after 3 cycles → `req_rdy[0]` same cycle, `rsp_vld[0]=1` with `rsp_y=4` the cycle after `isqrt_y_vld`, `busy` back to 0.
- **Round-robin fairness:** all 4 requesters held valid (x=1,4,9,25), ideal fixed-latency isqrt → grants 0,1,2,3,0…; responses 1,2,3,5 delivered to matching `rsp_vld` bits in order.
- **Backpressure:** `MAX_OUT=8`, isqrt stalls results → exactly 8 grants, then `req_rdy=0` and state `st_full`. Release one result → one new grant the following cycle.
- **Simultaneous push/pop at count=3:** count stays 3; the tag for the new grant lands behind the popped one.
- **Stray result:** `isqrt_y_vld` with FIFO empty → `err=1` sticky, no `rsp_vld`. `rst` clears it.
- **Reset mid-operation:** 5 outstanding, assert `rst` for one cycle → all outputs at reset values, `ptr=0`, subsequent request to requester 2 granted and returned correctly.
